peripheral_counter_fifo_core: RTL and testbench
===============================================

Name: peripheral_counter_fifo_core

Overview:
Parametrised next-generation counter/FIFO peripheral core. It sits behind the bus register decoder and drives that decoder through native register signals. Compared with the previous core it adds:
- generic widths and depth
- a programmable reload/terminal value with wrap mode
- a sticky interrupt with clear
- FIFO overflow/underflow error flags

Parameters:
COUNT_WIDTH, 32, counter/reload register width (>=2)
FIFO_WIDTH, 8, FIFO data width
FIFO_DEPTH, 16, FIFO entries; power of 2, >=2
THRESHOLD, 1000, compare value for lt_thresh_out (must fit COUNT_WIDTH)
CW, $clog2(FIFO_DEPTH+1), derived, word-count width (localparam)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
count_we  in  1  load count_in into counter
count_in  in  COUNT_WIDTH  counter write data
reload_we  in  1  load reload_in into reload register
reload_in  in  COUNT_WIDTH  reload write data
config_we  in  1  load en/dir/ire/wrap inputs
en_in / dir_in / ire_in / wrap_in  in  1 each  enable, direction (1=down), interrupt enable, wrap mode
fifo_we  in  1  push fifo_data_in
fifo_data_in  in  FIFO_WIDTH  push data
fifo_re  in  1  pop head entry
irq_clr  in  1  clear irq pending
err_clr  in  1  clear fifo_overflow/fifo_underflow
count_out  out  COUNT_WIDTH  counter value
reload_out  out  COUNT_WIDTH  reload register
en_out / dir_out / ire_out / wrap_out  out  1 each  config readback
lt_thresh_out  out  1  count_out < THRESHOLD
irq  out  1  sticky interrupt pending
fifo_empty / fifo_full  out  1 each  FIFO status
fifo_word_count  out  CW  entries held (0..FIFO_DEPTH)
fifo_data_out  out  FIFO_WIDTH  head entry (first-word fall-through), 0 when empty
fifo_overflow / fifo_underflow  out  1 each  sticky error flags

Behaviour:
- Reset values: count 0, reload all-ones, en/dir/ire/wrap 0, irq 0, FIFO empty (word_count 0, empty 1, full 0, data_out 0), error flags 0.
- Reset mid-operation: everything returns to reset values immediately; FIFO contents are discarded.
- Counter update, per cycle, in priority order:
  1. count_we: load count_in; no terminal event that cycle.
  2. Else if en=1 and dir=0 (up):
     - count==reload: terminal event; next = 0 if wrap, else hold.
     - otherwise count+1.
  3. Else if en=1 and dir=1 (down):
     - count==0: terminal event; next = reload if wrap, else hold 0.
     - otherwise count-1.
- Terminal event repeats every cycle while holding (non-wrap) with en=1.
- Arithmetic is modulo 2^COUNT_WIDTH.
- Counter reads and config writes:
  - Writes to config or reload take effect next cycle.
  - The counter step in the same cycle uses the old values.
- Interrupt:
  - irq sets on a terminal event when ire=1 (the current ire, not one being written).
  - irq_clr clears it; if set and clear coincide, set wins.
  - irq is registered: it rises one cycle after the terminal-event cycle.
- lt_thresh_out is combinational from the count register.
- FIFO (circular buffer; read/write pointers of $clog2(FIFO_DEPTH)+1 bits):
  - Push accepted if not full, or if full with a simultaneous valid pop.
  - Push rejected when full without a pop: data dropped, fifo_overflow set.
  - Pop on empty: no state change, fifo_underflow set.
  - Push and pop together on empty: push only; underflow set; word_count becomes 1.
  - Push and pop together when neither empty nor full: word_count unchanged, head advances.
  - fifo_data_out shows the new head in the cycle after a pop.
  - Error flags clear on err_clr; a set in the same cycle as err_clr wins.

Test Plan:
- Reset, then reload_we=1 with reload_in=5; wrap=1, en=1, up → count sequence 0,1,2,3,4,5,0; irq stays 0 (ire=0).
- Same as above but ire=1 and wrap=0 → count holds at 5; irq=1 the cycle after count reaches 5; irq_clr is ignored while count holds (set wins); irq clears once en=0 and irq_clr is pulsed.
- dir=1, wrap=1, count_we with 2, reload 7 → 2,1,0,7,6; one terminal event at 0; count_we=9 with en=1 → next count 9, no increment.
- Push FIFO_DEPTH values 0x10..0x1F → full=1, word_count=16, data_out=0x10; a 17th push sets overflow, count stays 16; push and pop together → data_out=0x11, count 16.
- Pop on empty → underflow=1, count 0; push and pop together on empty → count 1, data_out=pushed value; err_clr → flags 0.
- count_in=999 → lt_thresh_out=1; count 1000 → 0; assert reset while en=1 and FIFO half full → all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/peripheral_counter_fifo_core.sv
// Counter/FIFO peripheral core: reloadable up/down counter with sticky irq, plus a
// first-word-fall-through FIFO with sticky overflow/underflow flags.
module peripheral_counter_fifo_core #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned FIFO_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned THRESHOLD   = 1000,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   count_we,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   reload_we,
  input  logic [COUNT_WIDTH-1:0] reload_in,
  input  logic                   config_we,
  input  logic                   en_in,
  input  logic                   dir_in,
  input  logic                   ire_in,
  input  logic                   wrap_in,
  input  logic                   fifo_we,
  input  logic [FIFO_WIDTH-1:0]  fifo_data_in,
  input  logic                   fifo_re,
  input  logic                   irq_clr,
  input  logic                   err_clr,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic [COUNT_WIDTH-1:0] reload_out,
  output logic                   en_out,
  output logic                   dir_out,
  output logic                   ire_out,
  output logic                   wrap_out,
  output logic                   lt_thresh_out,
  output logic                   irq,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [CW-1:0]          fifo_word_count,
  output logic [FIFO_WIDTH-1:0]  fifo_data_out,
  output logic                   fifo_overflow,
  output logic                   fifo_underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [COUNT_WIDTH-1:0] ThreshVal = COUNT_WIDTH'(THRESHOLD);
  localparam logic [COUNT_WIDTH-1:0] One       = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] count_q, count_d, reload_q;
  logic                   en_q, dir_q, ire_q, wrap_q;
  logic                   irq_q, irq_d, term;

  logic [PW-1:0]          wptr_q, rptr_q, wptr_d, rptr_d;
  logic [FIFO_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic                   ovf_q, ovf_d, unf_q, unf_d;
  logic                   empty, full, push_ok, pop_ok;

  // Counter step always uses the registered config/reload, never the values being written.
  always_comb begin
    count_d = count_q;
    term    = 1'b0;
    if (count_we) begin
      count_d = count_in;
    end else if (en_q && !dir_q) begin
      if (count_q == reload_q) begin
        term = 1'b1;
        if (wrap_q) count_d = '0;
      end else begin
        count_d = count_q + One;
      end
    end else if (en_q && dir_q) begin
      if (count_q == '0) begin
        term = 1'b1;
        if (wrap_q) count_d = reload_q;
      end else begin
        count_d = count_q - One;
      end
    end
  end

  always_comb begin
    irq_d = irq_q;
    if (term && ire_q) irq_d = 1'b1;
    else if (irq_clr)  irq_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '1;
      en_q     <= 1'b0;
      dir_q    <= 1'b0;
      ire_q    <= 1'b0;
      wrap_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      irq_q   <= irq_d;
      if (reload_we) reload_q <= reload_in;
      if (config_we) begin
        en_q   <= en_in;
        dir_q  <= dir_in;
        ire_q  <= ire_in;
        wrap_q <= wrap_in;
      end
    end
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = fifo_we && (!full || fifo_re);
  assign pop_ok  = fifo_re && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop_ok)  rptr_d = rptr_q + PW'(1);
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (fifo_we && full && !fifo_re) ovf_d = 1'b1;
    if (fifo_re && empty)            unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= fifo_data_in;
  end

  assign count_out       = count_q;
  assign reload_out      = reload_q;
  assign en_out          = en_q;
  assign dir_out         = dir_q;
  assign ire_out         = ire_q;
  assign wrap_out        = wrap_q;
  assign lt_thresh_out   = (count_q < ThreshVal);
  assign irq             = irq_q;
  assign fifo_empty      = empty;
  assign fifo_full       = full;
  assign fifo_word_count = CW'(wptr_q - rptr_q);
  assign fifo_data_out   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign fifo_overflow   = ovf_q;
  assign fifo_underflow  = unf_q;

endmodule

// File: tb/tb_peripheral_counter_fifo_core.sv
// Scoreboard bench: stimulus queues expected values tagged with a due cycle; a negedge
// monitor pops and compares them against the DUT.
module tb_peripheral_counter_fifo_core;

  localparam int unsigned CW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        count_we, reload_we, config_we;
  logic [31:0] count_in, reload_in;
  logic        en_in, dir_in, ire_in, wrap_in;
  logic        fifo_we, fifo_re, irq_clr, err_clr;
  logic [7:0]  fifo_data_in;
  logic [31:0] count_out, reload_out;
  logic        en_out, dir_out, ire_out, wrap_out, lt_thresh_out, irq;
  logic        fifo_empty, fifo_full, fifo_overflow, fifo_underflow;
  logic [CW-1:0] fifo_word_count;
  logic [7:0]  fifo_data_out;

  peripheral_counter_fifo_core dut (
    .clk(clk), .reset(reset),
    .count_we(count_we), .count_in(count_in),
    .reload_we(reload_we), .reload_in(reload_in),
    .config_we(config_we), .en_in(en_in), .dir_in(dir_in), .ire_in(ire_in), .wrap_in(wrap_in),
    .fifo_we(fifo_we), .fifo_data_in(fifo_data_in), .fifo_re(fifo_re),
    .irq_clr(irq_clr), .err_clr(err_clr),
    .count_out(count_out), .reload_out(reload_out),
    .en_out(en_out), .dir_out(dir_out), .ire_out(ire_out), .wrap_out(wrap_out),
    .lt_thresh_out(lt_thresh_out), .irq(irq),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_word_count(fifo_word_count),
    .fifo_data_out(fifo_data_out),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
  );

  always #5 clk = ~clk;

  typedef enum int {SCount, SReload, SEn, SIrq, SLt, SEmpty, SFull, SWc, SDout, SOvf, SUnf} sig_e;
  typedef struct {
    int unsigned due;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] read_sig(input sig_e s);
    case (s)
      SCount:  return count_out;
      SReload: return reload_out;
      SEn:     return {31'd0, en_out};
      SIrq:    return {31'd0, irq};
      SLt:     return {31'd0, lt_thresh_out};
      SEmpty:  return {31'd0, fifo_empty};
      SFull:   return {31'd0, fifo_full};
      SWc:     return {27'd0, fifo_word_count};
      SDout:   return {24'd0, fifo_data_out};
      SOvf:    return {31'd0, fifo_overflow};
      default: return {31'd0, fifo_underflow};
    endcase
  endfunction

  // Monitor: compare every entry that has come due, keep the rest.
  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    foreach (exp_q[i]) begin
      if (exp_q[i].due <= cyc) begin
        logic [31:0] act;
        act = read_sig(exp_q[i].sig);
        n_checks++;
        if (act === exp_q[i].val) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                      exp_q[i].name, cyc, act, exp_q[i].val);
      end else begin
        keep.push_back(exp_q[i]);
      end
    end
    exp_q = keep;
  end

  task automatic exp_at(input string nm, input sig_e s, input logic [31:0] v,
                        input int unsigned dly);
    exp_t e;
    e.due = cyc + dly;
    e.sig = s;
    e.val = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic en, input logic dir, input logic ire, input logic wrap);
    config_we = 1'b1;
    en_in = en; dir_in = dir; ire_in = ire; wrap_in = wrap;
  endtask

  logic [31:0] up_seq [7] = '{0, 1, 2, 3, 4, 5, 0};

  initial begin
    reset = 1'b1;
    {count_we, reload_we, config_we, en_in, dir_in, ire_in, wrap_in} = '0;
    {fifo_we, fifo_re, irq_clr, err_clr} = '0;
    count_in = '0; reload_in = '0; fifo_data_in = '0;
    tick(2);

    n_checks++;
    if (count_out === 32'd0) n_pass++;
    else $display("FAIL direct_rst_count: got 0x%0h", count_out);
    n_checks++;
    if (reload_out === 32'hFFFF_FFFF) n_pass++;
    else $display("FAIL direct_rst_reload: got 0x%0h", reload_out);
    n_checks++;
    if (fifo_empty === 1'b1) n_pass++;
    else $display("FAIL direct_rst_empty: got %0b", fifo_empty);
    n_checks++;
    if (irq === 1'b0) n_pass++;
    else $display("FAIL direct_rst_irq: got %0b", irq);

    reset = 1'b0;

    exp_at("rst_count", SCount, 0, 0);
    exp_at("rst_reload", SReload, 32'hFFFF_FFFF, 0);
    exp_at("rst_en", SEn, 0, 0);
    exp_at("rst_irq", SIrq, 0, 0);
    exp_at("rst_lt", SLt, 1, 0);
    exp_at("rst_empty", SEmpty, 1, 0);
    exp_at("rst_full", SFull, 0, 0);
    exp_at("rst_wc", SWc, 0, 0);
    exp_at("rst_dout", SDout, 0, 0);
    exp_at("rst_ovf", SOvf, 0, 0);
    exp_at("rst_unf", SUnf, 0, 0);

    // Up count with wrap at reload=5, interrupts disabled
    reload_we = 1'b1; reload_in = 5;
    set_cfg(1, 0, 0, 1);
    tick(1);
    reload_we = 1'b0; config_we = 1'b0;
    exp_at("up_reload", SReload, 5, 0);
    for (int k = 0; k < 7; k++) exp_at("up_wrap_seq", SCount, up_seq[k], k);
    exp_at("up_wrap_noirq", SIrq, 0, 6);
    tick(6);

    // Up count, hold at terminal with irq
    count_we = 1'b1; count_in = 0;
    set_cfg(1, 0, 1, 0);
    tick(1);
    count_we = 1'b0; config_we = 1'b0;
    exp_at("hold_start", SCount, 0, 0);
    exp_at("hold_at5", SCount, 5, 5);
    exp_at("irq_not_yet", SIrq, 0, 5);
    exp_at("hold_still5", SCount, 5, 6);
    exp_at("irq_rise", SIrq, 1, 6);
    tick(6);
    irq_clr = 1'b1;
    tick(1);
    exp_at("irq_set_wins", SIrq, 1, 0);
    exp_at("hold_held", SCount, 5, 0);
    irq_clr = 1'b0;
    set_cfg(0, 0, 1, 0);
    tick(1);
    config_we = 1'b0;
    exp_at("irq_last_term", SIrq, 1, 0);
    irq_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    exp_at("irq_cleared", SIrq, 0, 0);
    exp_at("hold_disabled", SCount, 5, 0);

    // Down count with wrap to reload=7
    count_we = 1'b1; count_in = 2;
    reload_we = 1'b1; reload_in = 7;
    set_cfg(1, 1, 1, 1);
    tick(1);
    count_we = 1'b0; reload_we = 1'b0; config_we = 1'b0;
    exp_at("dn_load2", SCount, 2, 0);
    exp_at("dn_1", SCount, 1, 1);
    exp_at("dn_0", SCount, 0, 2);
    exp_at("dn_irq_pre", SIrq, 0, 2);
    exp_at("dn_wrap7", SCount, 7, 3);
    exp_at("dn_irq_term", SIrq, 1, 3);
    exp_at("dn_6", SCount, 6, 4);
    tick(4);
    count_we = 1'b1; count_in = 9;
    tick(1);
    count_we = 1'b0;
    exp_at("load_beats_step", SCount, 9, 0);
    set_cfg(0, 0, 0, 0);
    irq_clr = 1'b1;
    tick(1);
    config_we = 1'b0; irq_clr = 1'b0;
    exp_at("dn_old_cfg_step", SCount, 8, 0);
    exp_at("dn_irq_clr", SIrq, 0, 0);

    // Threshold compare
    count_we = 1'b1; count_in = 999;
    tick(1);
    exp_at("lt_999", SLt, 1, 0);
    count_in = 1000;
    tick(1);
    count_we = 1'b0;
    exp_at("lt_1000", SLt, 0, 0);
    exp_at("cnt_1000", SCount, 1000, 0);
    n_checks++;
    if (lt_thresh_out === 1'b0) n_pass++;
    else $display("FAIL direct_lt_1000: got %0b", lt_thresh_out);

    // Fill FIFO
    fifo_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fifo_data_in = 8'(8'h10 + i);
      tick(1);
      exp_at("fill_wc", SWc, 32'(i + 1), 0);
      exp_at("fill_head", SDout, 8'h10, 0);
    end
    exp_at("fill_full", SFull, 1, 0);
    exp_at("fill_notempty", SEmpty, 0, 0);
    fifo_data_in = 8'h20;
    tick(1);
    exp_at("ovf_set", SOvf, 1, 0);
    exp_at("ovf_wc", SWc, 16, 0);
    exp_at("ovf_head", SDout, 8'h10, 0);
    fifo_data_in = 8'h21; fifo_re = 1'b1;
    tick(1);
    fifo_we = 1'b0; fifo_re = 1'b0;
    exp_at("full_pp_head", SDout, 8'h11, 0);
    exp_at("full_pp_wc", SWc, 16, 0);
    exp_at("full_pp_full", SFull, 1, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    exp_at("ovf_clr", SOvf, 0, 0);

    // Drain, then underflow cases
    fifo_re = 1'b1;
    exp_at("drain_last_head", SDout, 8'h21, 15);
    exp_at("drain_last_wc", SWc, 1, 15);
    exp_at("drain_empty", SEmpty, 1, 16);
    exp_at("drain_dout0", SDout, 0, 16);
    exp_at("drain_no_unf", SUnf, 0, 16);
    tick(16);
    tick(1);
    exp_at("unf_set", SUnf, 1, 0);
    exp_at("unf_wc", SWc, 0, 0);
    fifo_we = 1'b1; fifo_data_in = 8'h55;
    tick(1);
    fifo_we = 1'b0; fifo_re = 1'b0;
    exp_at("empty_pp_wc", SWc, 1, 0);
    exp_at("empty_pp_head", SDout, 8'h55, 0);
    exp_at("empty_pp_unf", SUnf, 1, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    exp_at("err_clr_unf", SUnf, 0, 0);
    exp_at("err_clr_ovf", SOvf, 0, 0);

    // Reset mid-operation
    fifo_we = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fifo_data_in = 8'(8'h60 + i);
      tick(1);
    end
    fifo_we = 1'b0;
    exp_at("half_wc", SWc, 8, 0);
    count_we = 1'b1; count_in = 3;
    set_cfg(1, 0, 1, 1);
    tick(1);
    count_we = 1'b0; config_we = 1'b0;
    tick(1);
    exp_at("pre_rst_count", SCount, 4, 0);
    tick(1);
    exp_at("mid_rst_count", SCount, 0, 0);
    exp_at("mid_rst_reload", SReload, 32'hFFFF_FFFF, 0);
    exp_at("mid_rst_en", SEn, 0, 0);
    exp_at("mid_rst_wc", SWc, 0, 0);
    exp_at("mid_rst_empty", SEmpty, 1, 0);
    exp_at("mid_rst_dout", SDout, 0, 0);
    exp_at("mid_rst_irq", SIrq, 0, 0);
    exp_at("mid_rst_lt", SLt, 1, 0);
    reset = 1'b1;
    #1;
    n_checks++;
    if (count_out === 32'd0) n_pass++;
    else $display("FAIL direct_mid_rst_count: got 0x%0h", count_out);
    n_checks++;
    if (fifo_word_count === '0) n_pass++;
    else $display("FAIL direct_mid_rst_wc: got 0x%0h", fifo_word_count);
    tick(1);
    reset = 1'b0;
    exp_at("post_rst_count", SCount, 0, 0);
    tick(2);

    foreach (exp_q[i]) begin
      n_checks++;
      $display("FAIL %s: never compared, expected 0x%0h", exp_q[i].name, exp_q[i].val);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
